// File: rtl/majority_vote_scheduler.sv
// Round-robin scheduler that time-shares one 3-input majority detector
// among NREQ requesters and returns each result with its requester index.
module majority_vote_scheduler #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned ID_W  = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_val,
  output logic [NREQ-1:0]   req_rdy,
  input  logic [3*NREQ-1:0] req_votes,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic              resp_out,
  output logic [ID_W-1:0]   resp_id,
  output logic [CNT_W-1:0]  true_count,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [2:0]         vote_q, vote_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               resp_out_q, resp_out_d;
  logic [ID_W-1:0]    resp_id_q, resp_id_d;
  logic [CNT_W-1:0]   true_count_q, true_count_d;

  logic               grant_vld_c;
  logic [ID_W-1:0]    grant_id_c;
  logic [ID_W-1:0]    idx_c;
  logic [2:0]         grant_votes_c;

  // Round-robin search for the first valid requester starting at rr_ptr.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_id_c  = '0;
    idx_c       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_c = ID_W'((32'(rr_ptr_q) + k) % NREQ);
      if (!grant_vld_c && req_val[idx_c]) begin
        grant_vld_c = 1'b1;
        grant_id_c  = idx_c;
      end
    end
  end

  // Select the vote triple of the granted requester.
  always_comb begin
    grant_votes_c = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (ID_W'(k) == grant_id_c) begin
        grant_votes_c = req_votes[3*k +: 3];
      end
    end
  end

  // Ready is one-hot on the grant, only while idle and out of reset.
  always_comb begin
    req_rdy = '0;
    if (rst_n && (state_q == IDLE) && grant_vld_c) begin
      req_rdy[grant_id_c] = 1'b1;
    end
  end

  // Next-state and datapath update for the accept/evaluate/respond sequence.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    vote_d       = vote_q;
    id_d         = id_q;
    resp_out_d   = resp_out_q;
    resp_id_d    = resp_id_q;
    true_count_d = true_count_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld_c) begin
          vote_d  = grant_votes_c;
          id_d    = grant_id_c;
          state_d = EVAL;
        end
      end
      EVAL: begin
        resp_out_d = ((vote_q[0] | vote_q[1]) & vote_q[2]) | (vote_q[0] & vote_q[1]);
        resp_id_d  = id_q;
        state_d    = RESP;
      end
      RESP: begin
        if (resp_rdy) begin
          state_d  = IDLE;
          rr_ptr_d = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
          if (resp_out_q && (true_count_q != '1)) begin
            true_count_d = true_count_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      vote_q       <= '0;
      id_q         <= '0;
      resp_out_q   <= 1'b0;
      resp_id_q    <= '0;
      true_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      vote_q       <= vote_d;
      id_q         <= id_d;
      resp_out_q   <= resp_out_d;
      resp_id_q    <= resp_id_d;
      true_count_q <= true_count_d;
    end
  end

  assign resp_val   = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_out   = resp_out_q;
  assign resp_id    = resp_id_q;
  assign true_count = true_count_q;

endmodule

// File: tb/tb_majority_vote_scheduler.sv
// Self-checking bench for majority_vote_scheduler: vector table plus
// hand-written sequences, with a scoreboard matching responses to accepts.
module tb_majority_vote_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_val;
  logic [11:0] req_votes;
  logic        resp_rdy;

  logic [3:0]  req_rdy;
  logic        resp_val;
  logic        resp_out;
  logic [1:0]  resp_id;
  logic [7:0]  true_count;
  logic        busy;

  logic [3:0]  req_rdy_s;
  logic        resp_val_s;
  logic        resp_out_s;
  logic [1:0]  resp_id_s;
  logic [1:0]  true_count_s;
  logic        busy_s;

  always #5 clk = ~clk;

  majority_vote_scheduler #(.NREQ(4), .ID_W(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_val(req_val), .req_rdy(req_rdy),
    .req_votes(req_votes), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_out(resp_out), .resp_id(resp_id), .true_count(true_count), .busy(busy)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation checks.
  majority_vote_scheduler #(.NREQ(4), .ID_W(2), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .req_val(req_val), .req_rdy(req_rdy_s),
    .req_votes(req_votes), .resp_val(resp_val_s), .resp_rdy(resp_rdy),
    .resp_out(resp_out_s), .resp_id(resp_id_s), .true_count(true_count_s), .busy(busy_s)
  );

  typedef struct {
    logic [1:0] id;
    logic [2:0] votes;
    logic       exp_out;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic       out;
  } exp_t;

  exp_t       sb_q[$];
  logic [1:0] grants[$];
  int         acc_cyc[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_acc = 0;
  int         n_resp = 0;
  int         cyc = 0;
  logic       last_out = 1'b0;
  logic [1:0] last_id = 2'd0;
  logic [7:0] exp_cnt = 8'd0;
  logic [1:0] exp_cnt_s = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic maj(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Monitor: pushes expected results on accepts, pops and compares on responses.
  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] idx;
    logic [11:0] sh;
    logic       ok;
    cyc++;
    if (rst_n) begin
      ok = ($countones(req_rdy) <= 1);
      check("rdy_onehot", 32'(ok), 32'd1);
      check("true_count", 32'(true_count), 32'(exp_cnt));
      check("true_count_sat", 32'(true_count_s), 32'(exp_cnt_s));
      if ((req_rdy & req_val) != 4'd0) begin
        idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
          if (req_rdy[k] && req_val[k]) idx = 2'(k);
        end
        sh    = req_votes >> (3 * int'(idx));
        e.id  = idx;
        e.out = maj(sh[2:0]);
        sb_q.push_back(e);
        grants.push_back(idx);
        acc_cyc.push_back(cyc);
        n_acc++;
      end
      if (resp_val && resp_rdy) begin
        if (sb_q.size() == 0) begin
          fail_now("sb_unexpected_resp");
        end else begin
          e = sb_q.pop_front();
          check("sb_resp_out", 32'(resp_out), 32'(e.out));
          check("sb_resp_id", 32'(resp_id), 32'(e.id));
          if (e.out) begin
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            if (exp_cnt_s != 2'h3) exp_cnt_s = exp_cnt_s + 2'd1;
          end
        end
        last_out = resp_out;
        last_id  = resp_id;
        n_resp++;
      end
    end
  end

  task automatic clear_model();
    sb_q.delete();
    exp_cnt   = 8'd0;
    exp_cnt_s = 2'd0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_req_rdy", 32'(req_rdy), 32'd0);
    check("rst_resp_val", 32'(resp_val), 32'd0);
    check("rst_resp_out", 32'(resp_out), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_true_count", 32'(true_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic do_req(input logic [1:0] id, input logic [2:0] v);
    int t;
    int a0;
    int r0;
    a0 = n_acc;
    r0 = n_resp;
    @(posedge clk);
    #1;
    req_votes[3*id +: 3] = v;
    req_val[id] = 1'b1;
    t = 0;
    while (n_acc == a0 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 20) fail_now("accept_timeout");
    req_val[id] = 1'b0;
    req_votes[3*id +: 3] = ~v;
    t = 0;
    while (n_resp == r0 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 20) fail_now("resp_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    logic [1:0] rr_exp[6];
    logic [1:0] sat_exp[5];
    int t;
    int a0;
    int r0;

    tbl[0]  = '{2'd0, 3'b000, 1'b0};
    tbl[1]  = '{2'd0, 3'b001, 1'b0};
    tbl[2]  = '{2'd0, 3'b010, 1'b0};
    tbl[3]  = '{2'd0, 3'b011, 1'b1};
    tbl[4]  = '{2'd0, 3'b100, 1'b0};
    tbl[5]  = '{2'd0, 3'b101, 1'b1};
    tbl[6]  = '{2'd0, 3'b110, 1'b1};
    tbl[7]  = '{2'd0, 3'b111, 1'b1};
    tbl[8]  = '{2'd2, 3'b101, 1'b1};
    tbl[9]  = '{2'd3, 3'b011, 1'b1};
    tbl[10] = '{2'd1, 3'b100, 1'b0};
    tbl[11] = '{2'd3, 3'b010, 1'b0};
    rr_exp  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    rst_n     = 1'b0;
    req_val   = 4'd0;
    req_votes = 12'd0;
    resp_rdy  = 1'b1;
    #1;
    check("init_resp_val", 32'(resp_val), 32'd0);
    check("init_busy", 32'(busy), 32'd0);
    check("init_true_count", 32'(true_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request from requester 2, cycle by cycle.
    @(posedge clk);
    #1;
    req_votes = 12'b000_101_000_000;
    req_val   = 4'b0100;
    @(negedge clk);
    check("single_req_rdy", 32'(req_rdy), 32'h4);
    check("single_idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    req_val   = 4'd0;
    req_votes = 12'd0;
    @(negedge clk);
    check("single_eval_busy", 32'(busy), 32'd1);
    check("single_eval_val", 32'(resp_val), 32'd0);
    check("single_eval_rdy", 32'(req_rdy), 32'd0);
    @(negedge clk);
    check("single_resp_val", 32'(resp_val), 32'd1);
    check("single_resp_out", 32'(resp_out), 32'd1);
    check("single_resp_id", 32'(resp_id), 32'd2);
    @(negedge clk);
    check("single_after_val", 32'(resp_val), 32'd0);
    check("single_true_count", 32'(true_count), 32'd1);

    // Mid-stream reset, then the vector table.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      do_req(tbl[i].id, tbl[i].votes);
      check("tbl_resp_out", 32'(last_out), 32'(tbl[i].exp_out));
      check("tbl_resp_id", 32'(last_id), 32'(tbl[i].id));
      if (i == 7) begin
        check("sweep_true_count", 32'(true_count), 32'd4);
        check("sweep_true_count_sat", 32'(true_count_s), 32'd3);
      end
    end
    check("tbl_true_count", 32'(true_count), 32'd6);

    // All requesters continuously valid: round-robin order and spacing.
    do_reset();
    grants.delete();
    acc_cyc.delete();
    a0 = n_acc;
    r0 = n_resp;
    @(posedge clk);
    #1;
    req_votes = 12'b111_011_100_001;
    req_val   = 4'hF;
    t = 0;
    while (n_acc < a0 + 6 && t < 60) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 60) fail_now("rr_accept_timeout");
    req_val = 4'd0;
    t = 0;
    while (n_resp < r0 + 6 && t < 30) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 30) fail_now("rr_resp_timeout");
    if (grants.size() < 6) begin
      fail_now("rr_too_few_grants");
    end else begin
      for (int i = 0; i < 6; i++) begin
        check("rr_grant_order", 32'(grants[i]), 32'(rr_exp[i]));
        if (i > 0) check("rr_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
      end
    end

    // Backpressure on requester 0, then resume; next grant is after id 0.
    @(posedge clk);
    #1;
    resp_rdy = 1'b0;
    a0 = n_acc;
    req_votes[2:0] = 3'b110;
    req_val = 4'b0001;
    t = 0;
    while (n_acc == a0 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 20) fail_now("bp_accept_timeout");
    req_val = 4'd0;
    req_votes[2:0] = 3'b000;
    t = 0;
    while (!resp_val && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) fail_now("bp_resp_val_timeout");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      req_val = 4'b1001;
      @(negedge clk);
      check("bp_resp_val", 32'(resp_val), 32'd1);
      check("bp_resp_out", 32'(resp_out), 32'd1);
      check("bp_resp_id", 32'(resp_id), 32'd0);
      check("bp_req_rdy", 32'(req_rdy), 32'd0);
    end
    @(posedge clk);
    #1;
    resp_rdy = 1'b1;
    a0 = n_acc;
    r0 = n_resp;
    t = 0;
    while (n_acc == a0 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 20) fail_now("bp_regrant_timeout");
    req_val = 4'd0;
    check("bp_one_handshake", 32'(n_resp - r0), 32'd1);
    if (grants.size() == 0) fail_now("bp_no_grant");
    else check("bp_next_grant", 32'(grants[grants.size()-1]), 32'd3);
    t = 0;
    while (n_resp < r0 + 2 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 20) fail_now("bp_final_resp_timeout");
    check("bp_final_id", 32'(last_id), 32'd3);

    // Saturation of the 2-bit counter.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_req(2'd1, 3'b111);
      check("sat_count", 32'(true_count_s), 32'(sat_exp[i]));
    end
    check("sat_wide_count", 32'(true_count), 32'd5);

    // Reset while in EVAL: the aborted request never responds.
    a0 = n_acc;
    @(posedge clk);
    #1;
    req_votes[5:3] = 3'b111;
    req_val = 4'b0010;
    t = 0;
    while (n_acc == a0 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 20) fail_now("abort_accept_timeout");
    req_val = 4'd0;
    check("abort_in_eval", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_resp_val", 32'(resp_val), 32'd0);
    check("abort_count_sat", 32'(true_count_s), 32'd0);
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_resp", 32'(resp_val), 32'd0);
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/majority_vote_scheduler.md
Name: majority_vote_scheduler

Overview:
- Shares one 3-input pair/triple (majority) detector among NREQ requesters.
- Each requester presents a 3-bit vote vector under a val/rdy handshake; requesters are granted in round-robin order.
- The scheduler registers the granted votes, evaluates them, and returns the 1-bit result with the requester index on a val/rdy response port.
- Sits between requester-side control logic and downstream consumers; also keeps a saturating count of true results.

Parameters:
- NREQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester index (= clog2(NREQ), set by instantiator)
- CNT_W, 8, width of saturating true-result counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous reset, active-low
- req_val  input  NREQ  per-requester valid
- req_rdy  output  NREQ  per-requester ready (one-hot or zero)
- req_votes  input  3*NREQ  requester i votes at bits [3i+2:3i]; bit 3i = in0, 3i+1 = in1, 3i+2 = in2
- resp_val  output  1  result valid
- resp_rdy  input  1  consumer ready
- resp_out  output  1  detector result: 1 when two or more of the three votes are 1
- resp_id  output  ID_W  index of requester that produced resp_out
- true_count  output  CNT_W  number of accepted responses with resp_out=1, saturating
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - state=IDLE, rr_ptr=0, req_rdy=0, resp_val=0, resp_out=0, resp_id=0, true_count=0, busy=0.
  - Applies regardless of state; any in-flight request or pending response is discarded with no handshake.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - Grant = first i with req_val[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_rdy is combinational: req_rdy[grant]=1 only in IDLE with a valid request; otherwise all zero. req_rdy never depends on resp_rdy.
  - On the handshake edge: latch the granted 3-bit votes into vote_reg and the grant index into id_reg, then go to EVAL.
  - No req_val set: remain in IDLE.
- EVAL:
  - resp_out_reg <= (in0|in1)&in2 | (in0&in1), computed from vote_reg.
  - resp_id <= id_reg; go to RESP.
  - All req_rdy = 0.
- RESP:
  - resp_val=1; resp_out and resp_id are held stable until the handshake.
  - On edge with resp_rdy=1: go to IDLE; rr_ptr <= (id_reg+1) mod NREQ; if resp_out=1 and true_count != all-ones, true_count increments.
  - While resp_rdy=0: stay in RESP indefinitely with no output changes.
- Latency and throughput:
  - Request accepted at edge t gives resp_val=1 in the cycle after edge t+1, i.e. 2 cycles.
  - Minimum 3 cycles per transaction with resp_rdy tied high.
- Fairness: rr_ptr advances only on a completed response handshake. With all requesters continuously valid, grant order is 0,1,2,...,NREQ-1,0,...
- Boundary conditions:
  - Dropping req_val before the grant is allowed; the requester simply is not granted.
  - Votes are sampled only on the handshake edge; later changes do not affect the result.
  - rr_ptr wraps from NREQ-1 to 0.
  - true_count saturates at 2^CNT_W-1 and does not wrap.
  - resp_id is meaningful only while resp_val=1, but it holds its last value otherwise.

Test Plan:
- Reset with all inputs quiet: deassert rst_n mid-stream -> all outputs 0 immediately (before the next clk edge); after release, busy=0, true_count=0.
- Single request, requester 2, votes=3'b101, resp_rdy=1: req_rdy=4'b0100 for one cycle; two cycles later resp_val=1, resp_out=1, resp_id=2; true_count becomes 1.
- Truth table sweep on requester 0, votes 000..111 -> resp_out 0,0,0,1,0,1,1,1; true_count=4 at end.
- All four requesters valid continuously, resp_rdy=1 -> resp_id sequence 0,1,2,3,0,1; each request 3 cycles apart; req_rdy is never multi-hot.
- Backpressure: resp_rdy=0 for 5 cycles while in RESP -> resp_val, resp_out and resp_id stable, all req_rdy=0, rr_ptr unchanged. Raise resp_rdy -> one handshake, next grant goes to the next valid requester after the served id.
- Saturation with CNT_W=2: five requests with votes=3'b111 -> true_count goes 1,2,3,3,3. Then assert reset while in EVAL -> state IDLE, resp_val never asserted for the aborted request.
